// File: rtl/multi_dataflow_sobel_mdc_job_ctrl_pkg.sv
// Shared types and constants for the sobel MDC job sequencer: FSM state
// encoding, job descriptor layout and the fixed size-word transfer count.
package multi_dataflow_sobel_mdc_package;

    localparam int unsigned JOB_ADDR_WIDTH = 32;
    localparam int unsigned JOB_DIM_WIDTH  = 16;
    localparam int unsigned IN_SIZE_TRANS  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SIZE_REQ = 3'd1,
        ST_PEL_REQ  = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } job_state_e;

    typedef struct packed {
        logic [JOB_ADDR_WIDTH-1:0] in_size_addr;
        logic [JOB_ADDR_WIDTH-1:0] in_pel_addr;
        logic [JOB_ADDR_WIDTH-1:0] out_pel_addr;
        logic [JOB_DIM_WIDTH-1:0]  width;
        logic [JOB_DIM_WIDTH-1:0]  height;
    } job_cfg_t;

endpackage

// File: rtl/multi_dataflow_sobel_mdc_job_ctrl_if.sv
// Control bundle between the HWPE controller/register file (master) and the
// job sequencer (slave), including the streamer start/done handshakes.
interface multi_dataflow_sobel_mdc_job_ctrl_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DIM_WIDTH   = 16,
    parameter int unsigned TRANS_WIDTH = 32
) ();
    logic                   clear_i;
    logic                   start_i;
    logic [ADDR_WIDTH-1:0]  in_pel_addr_i;
    logic [ADDR_WIDTH-1:0]  in_size_addr_i;
    logic [ADDR_WIDTH-1:0]  out_pel_addr_i;
    logic [DIM_WIDTH-1:0]   width_i;
    logic [DIM_WIDTH-1:0]   height_i;
    logic                   in_size_ready_start_i;
    logic                   in_pel_ready_start_i;
    logic                   out_pel_ready_start_i;
    logic                   in_pel_done_i;
    logic                   out_pel_done_i;
    logic                   in_size_req_start_o;
    logic                   in_pel_req_start_o;
    logic                   out_pel_req_start_o;
    logic [ADDR_WIDTH-1:0]  in_size_base_o;
    logic [ADDR_WIDTH-1:0]  in_pel_base_o;
    logic [ADDR_WIDTH-1:0]  out_pel_base_o;
    logic [TRANS_WIDTH-1:0] in_size_trans_o;
    logic [TRANS_WIDTH-1:0] pel_trans_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;

    modport slave (
        input  clear_i, start_i, in_pel_addr_i, in_size_addr_i, out_pel_addr_i,
               width_i, height_i, in_size_ready_start_i, in_pel_ready_start_i,
               out_pel_ready_start_i, in_pel_done_i, out_pel_done_i,
        output in_size_req_start_o, in_pel_req_start_o, out_pel_req_start_o,
               in_size_base_o, in_pel_base_o, out_pel_base_o, in_size_trans_o,
               pel_trans_o, busy_o, done_o, err_o
    );

    modport master (
        output clear_i, start_i, in_pel_addr_i, in_size_addr_i, out_pel_addr_i,
               width_i, height_i, in_size_ready_start_i, in_pel_ready_start_i,
               out_pel_ready_start_i, in_pel_done_i, out_pel_done_i,
        input  in_size_req_start_o, in_pel_req_start_o, out_pel_req_start_o,
               in_size_base_o, in_pel_base_o, out_pel_base_o, in_size_trans_o,
               pel_trans_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/multi_dataflow_sobel_mdc_job_ctrl_done_tracker.sv
// Sticky capture of the source and sink done pulses; all_done_o already
// includes pulses arriving in the current cycle.
module multi_dataflow_sobel_mdc_done_tracker (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic in_done_i,
    input  logic out_done_i,
    output logic all_done_o
);
    logic r_in_done;
    logic r_out_done;

    // sticky done bits, only armed while the job is running
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_done  <= 1'b0;
            r_out_done <= 1'b0;
        end else if (clr_i) begin
            r_in_done  <= 1'b0;
            r_out_done <= 1'b0;
        end else if (en_i) begin
            r_in_done  <= r_in_done  | in_done_i;
            r_out_done <= r_out_done | out_done_i;
        end else begin
            r_in_done  <= r_in_done;
            r_out_done <= r_out_done;
        end
    end

    assign all_done_o = en_i & (r_in_done | in_done_i) & (r_out_done | out_done_i);
endmodule

// File: rtl/multi_dataflow_sobel_mdc_job_ctrl.sv
// Job sequencer for the sobel MDC streamer: latches one job, starts the address
// generators in order, reports done/error. Macro SOBEL_MDC_JOB_CTRL_PERF_CNT_EN adds cycles_o.
module multi_dataflow_sobel_mdc_job_ctrl
    import multi_dataflow_sobel_mdc_package::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DIM_WIDTH   = 16,
    parameter int unsigned TRANS_WIDTH = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    multi_dataflow_sobel_mdc_job_ctrl_if.slave bus
`ifdef SOBEL_MDC_JOB_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycles_o
`endif
);
    job_state_e             r_state;
    job_state_e             w_next;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [ADDR_WIDTH-1:0]  r_in_size_base;
    logic [ADDR_WIDTH-1:0]  r_in_pel_base;
    logic [ADDR_WIDTH-1:0]  r_out_pel_base;
    logic [TRANS_WIDTH-1:0] r_in_size_trans;
    logic [TRANS_WIDTH-1:0] r_pel_trans;
    logic [TRANS_WIDTH-1:0] w_pel_trans;
    logic                   w_accept;
    logic                   w_zero;
    logic                   w_pel_go;
    logic                   w_all_done;

    assign w_accept    = (r_state == ST_IDLE) & bus.start_i & ~bus.clear_i;
    assign w_pel_trans = TRANS_WIDTH'(bus.width_i) * TRANS_WIDTH'(bus.height_i);
    assign w_zero      = (w_pel_trans == {TRANS_WIDTH{1'b0}});
    assign w_pel_go    = (r_state == ST_PEL_REQ) & bus.in_pel_ready_start_i
                       & bus.out_pel_ready_start_i & ~bus.clear_i;

    multi_dataflow_sobel_mdc_done_tracker u_done_tracker (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (bus.clear_i | (r_state != ST_RUN)),
        .en_i       (r_state == ST_RUN),
        .in_done_i  (bus.in_pel_done_i),
        .out_done_i (bus.out_pel_done_i),
        .all_done_o (w_all_done)
    );

    // next-state selection; an abort overrides every phase
    always_comb begin
        w_next = r_state;
        if (bus.clear_i) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_next = bus.start_i ? (w_zero ? ST_DONE : ST_SIZE_REQ) : ST_IDLE;
                ST_SIZE_REQ: w_next = bus.in_size_ready_start_i ? ST_PEL_REQ : ST_SIZE_REQ;
                ST_PEL_REQ:  w_next = w_pel_go ? ST_RUN : ST_PEL_REQ;
                ST_RUN:      w_next = w_all_done ? ST_DONE : ST_RUN;
                ST_DONE:     w_next = ST_IDLE;
                default:     w_next = ST_IDLE;
            endcase
        end
    end

    // state register with busy/done decoded one cycle ahead so both are flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // sticky zero-size error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (bus.clear_i) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_zero;
        end else begin
            r_err <= r_err;
        end
    end

    // job descriptor latch; held until the next accepted start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_size_base  <= {ADDR_WIDTH{1'b0}};
            r_in_pel_base   <= {ADDR_WIDTH{1'b0}};
            r_out_pel_base  <= {ADDR_WIDTH{1'b0}};
            r_in_size_trans <= {TRANS_WIDTH{1'b0}};
            r_pel_trans     <= {TRANS_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_in_size_base  <= bus.in_size_addr_i;
            r_in_pel_base   <= bus.in_pel_addr_i;
            r_out_pel_base  <= bus.out_pel_addr_i;
            r_in_size_trans <= TRANS_WIDTH'(IN_SIZE_TRANS);
            r_pel_trans     <= w_pel_trans;
        end else begin
            r_in_size_base  <= r_in_size_base;
            r_in_pel_base   <= r_in_pel_base;
            r_out_pel_base  <= r_out_pel_base;
            r_in_size_trans <= r_in_size_trans;
            r_pel_trans     <= r_pel_trans;
        end
    end

    // start pulses follow the generator ready flags in the same cycle
    assign bus.in_size_req_start_o = (r_state == ST_SIZE_REQ) & bus.in_size_ready_start_i & ~bus.clear_i;
    assign bus.in_pel_req_start_o  = w_pel_go;
    assign bus.out_pel_req_start_o = w_pel_go;
    assign bus.in_size_base_o      = r_in_size_base;
    assign bus.in_pel_base_o       = r_in_pel_base;
    assign bus.out_pel_base_o      = r_out_pel_base;
    assign bus.in_size_trans_o     = r_in_size_trans;
    assign bus.pel_trans_o         = r_pel_trans;
    assign bus.busy_o              = r_busy;
    assign bus.done_o              = r_done;
    assign bus.err_o               = r_err;

`ifdef SOBEL_MDC_JOB_CTRL_PERF_CNT_EN
    logic [31:0] r_cycles;

    // busy-cycle counter, restarted by each accepted job, saturating at all-ones
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycles <= 32'd0;
        end else if (w_accept) begin
            r_cycles <= 32'd0;
        end else if (r_busy && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end else begin
            r_cycles <= r_cycles;
        end
    end

    assign cycles_o = r_cycles;
`endif
endmodule

// File: tb/tb_multi_dataflow_sobel_mdc_job_ctrl.sv
// Randomized bench for the sobel MDC job sequencer against a job-level model
// of the sequencing rules; optional cycle counter checked under SOBEL_MDC_JOB_CTRL_PERF_CNT_EN.
module tb_multi_dataflow_sobel_mdc_job_ctrl;
    import multi_dataflow_sobel_mdc_package::*;

    logic clk;
    logic rst;
    multi_dataflow_sobel_mdc_job_ctrl_if bus ();
`ifdef SOBEL_MDC_JOB_CTRL_PERF_CNT_EN
    logic [31:0] cycles;
`endif

    multi_dataflow_sobel_mdc_job_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef SOBEL_MDC_JOB_CTRL_PERF_CNT_EN
        ,
        .cycles_o (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, obs, expv, $time);
    endtask

    // Job-level reference: which phase of the job we are in, what was latched.
    localparam int PH_IDLE = 0, PH_SIZE = 1, PH_PEL = 2, PH_RUN = 3, PH_FIN = 4;
    int          m_phase;
    int          m_jobs = 0;
    job_cfg_t    m_cfg;
    logic [31:0] m_trans, m_size_trans, m_cyc;
    logic        m_busy, m_done, m_err, got_in, got_out;
    bit          rst_hit = 1'b0;

    task automatic model_reset();
        m_phase = PH_IDLE; m_cfg = '0; m_trans = 32'd0; m_size_trans = 32'd0; m_cyc = 32'd0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; got_in = 1'b0; got_out = 1'b0;
    endtask

    task automatic model_step();
        longint prod;
        if (m_busy && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
        if (bus.clear_i) begin
            m_phase = PH_IDLE; m_err = 1'b0; got_in = 1'b0; got_out = 1'b0;
        end else begin
            case (m_phase)
                PH_IDLE: if (bus.start_i) begin
                    m_cfg.in_size_addr = bus.in_size_addr_i;
                    m_cfg.in_pel_addr  = bus.in_pel_addr_i;
                    m_cfg.out_pel_addr = bus.out_pel_addr_i;
                    m_cfg.width        = bus.width_i;
                    m_cfg.height       = bus.height_i;
                    prod         = longint'(m_cfg.width) * longint'(m_cfg.height);
                    m_trans      = prod[31:0];
                    m_size_trans = 32'd1;
                    m_err        = (prod == 64'd0);
                    m_cyc        = 32'd0;
                    m_jobs++;
                    m_phase = m_err ? PH_FIN : PH_SIZE;
                end
                PH_SIZE: if (bus.in_size_ready_start_i) m_phase = PH_PEL;
                PH_PEL:  if (bus.in_pel_ready_start_i && bus.out_pel_ready_start_i) m_phase = PH_RUN;
                PH_RUN: begin
                    got_in  = got_in  | bus.in_pel_done_i;
                    got_out = got_out | bus.out_pel_done_i;
                    if (got_in && got_out) begin
                        m_phase = PH_FIN; got_in = 1'b0; got_out = 1'b0;
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
        m_busy = (m_phase != PH_IDLE);
        m_done = (m_phase == PH_FIN);
    endtask

    task automatic check_outputs();
        logic exp_rs, exp_rp;
        exp_rs = (m_phase == PH_SIZE) && bus.in_size_ready_start_i && !bus.clear_i;
        exp_rp = (m_phase == PH_PEL) && bus.in_pel_ready_start_i && bus.out_pel_ready_start_i && !bus.clear_i;
        check_eq("busy",          64'(bus.busy_o),              64'(m_busy));
        check_eq("done",          64'(bus.done_o),              64'(m_done));
        check_eq("err",           64'(bus.err_o),               64'(m_err));
        check_eq("in_size_req",   64'(bus.in_size_req_start_o), 64'(exp_rs));
        check_eq("in_pel_req",    64'(bus.in_pel_req_start_o),  64'(exp_rp));
        check_eq("out_pel_req",   64'(bus.out_pel_req_start_o), 64'(exp_rp));
        check_eq("in_size_base",  64'(bus.in_size_base_o),      64'(m_cfg.in_size_addr));
        check_eq("in_pel_base",   64'(bus.in_pel_base_o),       64'(m_cfg.in_pel_addr));
        check_eq("out_pel_base",  64'(bus.out_pel_base_o),      64'(m_cfg.out_pel_addr));
        check_eq("in_size_trans", 64'(bus.in_size_trans_o),     64'(m_size_trans));
        check_eq("pel_trans",     64'(bus.pel_trans_o),         64'(m_trans));
`ifdef SOBEL_MDC_JOB_CTRL_PERF_CNT_EN
        check_eq("cycles",        64'(cycles),                  64'(m_cyc));
`endif
    endtask

    // First jobs are the directed ones (4x3, 0x7, max), later ones random with edge cases.
    function automatic logic [31:0] pick_dims(input int job);
        int r;
        case (job)
            0:       return {16'd4, 16'd3};
            1:       return {16'd0, 16'd7};
            2:       return {16'hFFFF, 16'hFFFF};
            default: begin
                r = $urandom_range(0, 9);
                if (r == 0)      return {16'd0, 16'($urandom_range(0, 9))};
                else if (r == 1) return {16'($urandom_range(1, 9)), 16'd0};
                else if (r == 2) return {16'hFFFF, 16'hFFFF};
                else             return {16'($urandom_range(1, 20)), 16'($urandom_range(1, 20))};
            end
        endcase
    endfunction

    task automatic drive_random();
        logic        easy;
        logic [31:0] dims;
        easy = (m_jobs < 3);
        dims = pick_dims(m_jobs);
        bus.start_i               = ($urandom_range(0, 3) == 0);
        bus.clear_i               = !easy && ($urandom_range(0, 49) == 0);
        bus.width_i               = dims[31:16];
        bus.height_i              = dims[15:0];
        bus.in_size_addr_i        = $urandom();
        bus.in_pel_addr_i         = $urandom();
        bus.out_pel_addr_i        = $urandom();
        bus.in_size_ready_start_i = easy || ($urandom_range(0, 9) < 6);
        bus.in_pel_ready_start_i  = easy || ($urandom_range(0, 9) < 6);
        bus.out_pel_ready_start_i = easy || ($urandom_range(0, 9) < 6);
        bus.in_pel_done_i         = ($urandom_range(0, 4) == 0);
        bus.out_pel_done_i        = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0; bus.clear_i = 1'b0;
        bus.in_size_addr_i = 32'd0; bus.in_pel_addr_i = 32'd0; bus.out_pel_addr_i = 32'd0;
        bus.width_i = 16'd0; bus.height_i = 16'd0;
        bus.in_size_ready_start_i = 1'b1; bus.in_pel_ready_start_i = 1'b1; bus.out_pel_ready_start_i = 1'b1;
        bus.in_pel_done_i = 1'b0; bus.out_pel_done_i = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            @(negedge clk);
            check_outputs();
            if (!rst_hit && c > 1000 && m_phase == PH_PEL) begin
                // asynchronous reset in the middle of the pel request phase
                #2 rst = 1'b1;
                #1 model_reset();
                check_outputs();
                bus.start_i = 1'b0;
                bus.clear_i = 1'b0;
                #1 rst = 1'b0;
                rst_hit = 1'b1;
            end
            model_step();
            @(posedge clk); #1;
        end
        check_eq("async_rst_in_pel_req", 64'(rst_hit), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
